// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the datapath (master) and mem_responder (slave).
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [5:0]  AddrIn;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        ack;
    logic        busy;
    logic        perr;

    modport master (
        output req, we, AddrIn, DataIn,
        input  DataOut, ack, busy, perr
    );

    modport slave (
        input  req, we, AddrIn, DataIn,
        output DataOut, ack, busy, perr
    );
endinterface

// File: rtl/mem_responder.sv
// 64 x 16 data memory with registered req/ack handshake and WAIT_CYCLES wait states.
// Optional even-parity protection per word when MEM_PARITY_EN is defined.
module mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_main,
    input  logic             reset,
    mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic              w_commit;

    logic              r_we;
    logic [5:0]        r_addr;
    logic [15:0]       r_data;
    logic              w_accept;
    logic              w_acc_we;
    logic [5:0]        w_acc_addr;
    logic [15:0]       w_acc_data;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_perr_next;

    logic [63:0][15:0] w_mem;
    logic [15:0]       r_dout;
    logic              r_ack;
    logic              r_busy;

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // w_commit marks the edge that enters RESP: the memory access happens there.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = S_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = 3'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_next = S_RESP;
                    w_cnt_next   = 3'd0;
                    w_commit     = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // With zero wait states the access commits on the acceptance edge itself,
    // so the request fields come straight from the bus in IDLE.
    assign w_accept   = (r_state == S_IDLE) && bus.req;
    assign w_acc_we   = (r_state == S_IDLE) ? bus.we     : r_we;
    assign w_acc_addr = (r_state == S_IDLE) ? bus.AddrIn : r_addr;
    assign w_acc_data = (r_state == S_IDLE) ? bus.DataIn : r_data;
    assign w_wr_en    = w_commit &  w_acc_we;
    assign w_rd_en    = w_commit & ~w_acc_we;

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= 6'd0;
            r_data <= 16'h0000;
        end else if (w_accept) begin
            r_we   <= bus.we;
            r_addr <= bus.AddrIn;
            r_data <= bus.DataIn;
        end
    end

`ifdef MEM_PARITY_EN
    logic [63:0] w_par;
`endif

    // Storage must clear on reset, so each word is a register with its own enable.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_word
            logic [15:0] r_word;
            always_ff @(posedge clk_main or negedge reset) begin
                if (!reset) begin
                    r_word <= 16'h0000;
                end else if (w_wr_en && (w_acc_addr == 6'(gi))) begin
                    r_word <= w_acc_data;
                end
            end
            assign w_mem[gi] = r_word;
`ifdef MEM_PARITY_EN
            logic r_par;
            always_ff @(posedge clk_main or negedge reset) begin
                if (!reset) begin
                    r_par <= 1'b0;
                end else if (w_wr_en && (w_acc_addr == 6'(gi))) begin
                    r_par <= ^w_acc_data;
                end
            end
            assign w_par[gi] = r_par;
`endif
        end
    endgenerate

`ifdef MEM_PARITY_EN
    assign w_perr_next = w_rd_en & (^{w_par[w_acc_addr], w_mem[w_acc_addr]});
`else
    assign w_perr_next = 1'b0;
`endif

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            r_dout <= 16'h0000;
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_dout <= w_mem[w_acc_addr];
            end
            r_ack  <= w_commit;
            r_busy <= (w_state_next != S_IDLE);
        end
    end

`ifdef MEM_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_next;
        end
    end
    assign bus.perr = r_perr;
`else
    assign bus.perr = w_perr_next;
`endif

    assign bus.DataOut = r_dout;
    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states, one with 0, sharing request inputs.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] din;

    int n_pass;
    int n_total;

    mem_responder_if bus_a();
    mem_responder_if bus_z();

    assign bus_a.req    = req;
    assign bus_a.we     = we;
    assign bus_a.AddrIn = addr;
    assign bus_a.DataIn = din;
    assign bus_z.req    = req;
    assign bus_z.we     = we;
    assign bus_z.AddrIn = addr;
    assign bus_z.DataIn = din;

    mem_responder #(.WAIT_CYCLES(2)) u_a (
        .clk_main (clk),
        .reset    (rst_n),
        .bus      (bus_a)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_z (
        .clk_main (clk),
        .reset    (rst_n),
        .bus      (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_dout;
    } vec_t;

    typedef struct {
        int          lat_a;
        int          busy_a;
        int          acks_a;
        int          perr_cnt_a;
        logic        perr_ack_a;
        logic [15:0] dout_a;
        int          lat_z;
        int          busy_z;
        int          acks_z;
        logic [15:0] dout_z;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One request, then an 8-cycle observation window sampled on falling edges.
    task automatic txn(input logic t_we, input logic [5:0] t_addr, input logic [15:0] t_data,
                       output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        req  = 1'b1;
        we   = t_we;
        addr = t_addr;
        din  = t_data;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus_a.busy) o.busy_a++;
            if (bus_a.perr) o.perr_cnt_a++;
            if (bus_a.ack) begin
                o.acks_a++;
                if (o.lat_a == 0) o.lat_a = i;
                o.dout_a     = bus_a.DataOut;
                o.perr_ack_a = bus_a.perr;
            end
            if (bus_z.busy) o.busy_z++;
            if (bus_z.ack) begin
                o.acks_z++;
                if (o.lat_z == 0) o.lat_z = i;
                o.dout_z = bus_z.DataOut;
            end
            if (i == 1) begin
                req  = 1'b0;
                addr = 6'd0;
                din  = 16'h0000;
            end
        end
        if (o.acks_a == 0) o.dout_a = bus_a.DataOut;
        if (o.acks_z == 0) o.dout_z = bus_z.DataOut;
        $display("txn we=%0d addr=%0d data=%h : A lat=%0d busy=%0d dout=%h | Z lat=%0d dout=%h",
                 t_we, t_addr, t_data, o.lat_a, o.busy_a, o.dout_a, o.lat_z, o.dout_z);
    endtask

    vec_t        vecs[10];
    obs_t        ob;
    logic [5:0]  held_tgt[3];
    logic [15:0] held_exp[3];
    int          held_ack_idx;

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{1'b0, 6'd5,  16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 6'd63, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 6'd63, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b0, 6'd0,  16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 6'd0,  16'h5A5A, 16'h0000};
        vecs[5] = '{1'b0, 6'd0,  16'h0000, 16'h5A5A};
        vecs[6] = '{1'b1, 6'd63, 16'h0F0F, 16'h5A5A};
        vecs[7] = '{1'b0, 6'd63, 16'h0000, 16'h0F0F};
        vecs[8] = '{1'b1, 6'd10, 16'h1234, 16'h0F0F};
        vecs[9] = '{1'b0, 6'd10, 16'h0000, 16'h1234};
        held_tgt = '{6'd63, 6'd0, 6'd63};
        held_exp = '{16'h0F0F, 16'h5A5A, 16'h0F0F};

        req   = 1'b0;
        we    = 1'b0;
        addr  = 6'd0;
        din   = 16'h0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy_a", 32'(bus_a.busy), 32'd0);
        chk("rst_ack_a",  32'(bus_a.ack),  32'd0);
        chk("rst_dout_a", 32'(bus_a.DataOut), 32'h0);
        chk("rst_perr_a", 32'(bus_a.perr), 32'd0);
        chk("rst_busy_z", 32'(bus_z.busy), 32'd0);
        chk("rst_ack_z",  32'(bus_z.ack),  32'd0);
        chk("rst_dout_z", 32'(bus_z.DataOut), 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            txn(vecs[v].we, vecs[v].addr, vecs[v].data, ob);
            chk($sformatf("v%0d_lat_a", v),  32'(ob.lat_a),  32'd3);
            chk($sformatf("v%0d_busy_a", v), 32'(ob.busy_a), 32'd3);
            chk($sformatf("v%0d_acks_a", v), 32'(ob.acks_a), 32'd1);
            chk($sformatf("v%0d_dout_a", v), 32'(ob.dout_a), 32'(vecs[v].exp_dout));
            chk($sformatf("v%0d_perr_a", v), 32'(ob.perr_cnt_a), 32'd0);
            chk($sformatf("v%0d_lat_z", v),  32'(ob.lat_z),  32'd1);
            chk($sformatf("v%0d_busy_z", v), 32'(ob.busy_z), 32'd1);
            chk($sformatf("v%0d_acks_z", v), 32'(ob.acks_z), 32'd1);
            chk($sformatf("v%0d_dout_z", v), 32'(ob.dout_z), 32'(vecs[v].exp_dout));
        end

        // Held req: loads accepted every 4 cycles, AddrIn during WAIT points elsewhere.
        held_ack_idx = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("held_ack_k%0d", k), 32'(bus_a.ack),
                    32'((k == 3) || (k == 7) || (k == 11)));
                if (bus_a.ack && held_ack_idx < 3) begin
                    chk($sformatf("held_dout_%0d", held_ack_idx), 32'(bus_a.DataOut),
                        32'(held_exp[held_ack_idx]));
                    held_ack_idx++;
                end
            end
            req  = (k <= 10);
            we   = 1'b0;
            addr = ((k % 4) == 0 && k < 12) ? held_tgt[k / 4] : 6'd10;
        end
        $display("held req: %0d acks seen", held_ack_idx);
        chk("held_ack_count", 32'(held_ack_idx), 32'd3);
        req  = 1'b0;
        addr = 6'd0;
        repeat (2) @(negedge clk);

        // Reset during WAIT of a store aborts it with no ack.
        req  = 1'b1;
        we   = 1'b1;
        addr = 6'd7;
        din  = 16'hAAAA;
        @(negedge clk);
        req = 1'b0;
        chk("ms_busy_before", 32'(bus_a.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ms_busy_rst", 32'(bus_a.busy), 32'd0);
        chk("ms_dout_rst", 32'(bus_a.DataOut), 32'h0);
        @(negedge clk);
        chk("ms_ack_rst", 32'(bus_a.ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ms_ack_after", 32'(bus_a.ack), 32'd0);
        $display("reset mid-store applied");
        txn(1'b0, 6'd7, 16'h0000, ob);
        chk("ms_ld7_lat_a",  32'(ob.lat_a),  32'd3);
        chk("ms_ld7_dout_a", 32'(ob.dout_a), 32'h0);
        chk("ms_ld7_dout_z", 32'(ob.dout_z), 32'h0);
        txn(1'b0, 6'd63, 16'h0000, ob);
        chk("ms_ld63_dout_a", 32'(ob.dout_a), 32'h0);

`ifdef MEM_PARITY_EN
        txn(1'b1, 6'd3, 16'h0001, ob);
        chk("par_st_perr", 32'(ob.perr_cnt_a), 32'd0);
        force u_a.g_word[3].r_par = 1'b0;
        txn(1'b0, 6'd3, 16'h0000, ob);
        chk("par_err_ack",  32'(ob.perr_ack_a), 32'd1);
        chk("par_err_cnt",  32'(ob.perr_cnt_a), 32'd1);
        chk("par_err_dout", 32'(ob.dout_a), 32'h0001);
        txn(1'b0, 6'd0, 16'h0000, ob);
        chk("par_ok_cnt", 32'(ob.perr_cnt_a), 32'd0);
        release u_a.g_word[3].r_par;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
